// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants for the 16-bit multicycle core: opcodes,
//                PC next-value selects and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Opcodes carried in instr[15:12]
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_NAND = 4'b0010;
    localparam logic [3:0] c_OP_SW   = 4'b1001;
    localparam logic [3:0] c_OP_LW   = 4'b1010;
    localparam logic [3:0] c_OP_BEQ  = 4'b1011;
    localparam logic [3:0] c_OP_JAL  = 4'b1101;
    localparam logic [3:0] c_OP_ADDI = 4'b1111;

    // PC next-value select; 2'b11 is reserved and leaves the PC unchanged
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Instruction field bit positions
    localparam int c_OP_MSB   = 15;
    localparam int c_OP_LSB   = 12;
    localparam int c_RA_MSB   = 11;
    localparam int c_RA_LSB   = 9;
    localparam int c_RB_MSB   = 8;
    localparam int c_RB_LSB   = 6;
    localparam int c_RC_MSB   = 2;
    localparam int c_RC_LSB   = 0;
    localparam int c_IMM_MSB  = 5;
    localparam int c_IMM_LSB  = 0;
    localparam int c_JOFF_MSB = 11;
    localparam int c_JOFF_LSB = 0;

endpackage : core_pkg
`default_nettype wire

// File: rtl/perf_counters.sv
`default_nettype none
// ============================================================================
//  Module      : perf_counters
//  Description : Free-running cycle counter and fetch (irwrite) counter.
//                Both wrap modulo 2^CNT_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irwrite,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;

    // Count every clock, and every clock that latches an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (irwrite) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign cycle_cnt = r_cycle_cnt;

endmodule : perf_counters
`default_nettype wire

// File: rtl/pc_ir_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ir_unit
//  Description : Fetch-side state holder: program counter, instruction
//                register, memory data register, decoded instruction fields
//                and performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ir_unit
    import core_pkg::*;
#(
    parameter int           W        = 16,
    parameter logic [W-1:0] PC_RESET = '0,
    parameter int           CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcwrite,
    input  logic             branch,
    input  logic             irwrite,
    input  logic [1:0]       pcsrc,
    input  logic             zero,
    input  logic [W-1:0]     aluresult,
    input  logic [W-1:0]     aluout,
    input  logic [W-1:0]     memrdata,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     instr,
    output logic [3:0]       op,
    output logic [2:0]       ra,
    output logic [2:0]       rb,
    output logic [2:0]       rc,
    output logic [W-1:0]     immext,
    output logic [W-1:0]     jtarget,
    output logic [W-1:0]     mdr,
    output logic             ir_valid,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    logic [W-1:0] r_pc;
    logic [W-1:0] r_instr;
    logic [W-1:0] r_mdr;
    logic         r_ir_valid;

    logic         w_pcen;
    logic [W-1:0] w_pc_next;
    logic [W-1:0] w_jtarget;

    // A taken branch is just a conditional pcwrite; pcwrite dominates
    assign w_pcen = pcwrite | (branch & zero);

    // Jump target keeps the current PC region and takes the 12-bit offset
    assign w_jtarget = {r_pc[W-1:c_JOFF_MSB+1], r_instr[c_JOFF_MSB:c_JOFF_LSB]};

    // Select the next PC; the reserved select holds the current value
    always_comb begin
        w_pc_next = r_pc;
        case (pcsrc)
            PCSRC_ALU:    w_pc_next = aluresult;
            PCSRC_ALUOUT: w_pc_next = aluout;
            PCSRC_JUMP:   w_pc_next = w_jtarget;
            default:      w_pc_next = r_pc;
        endcase
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else if (w_pcen) begin
            r_pc <= w_pc_next;
        end
    end

    // Instruction register and its sticky valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= '0;
            r_ir_valid <= 1'b0;
        end else if (irwrite) begin
            r_instr    <= memrdata;
            r_ir_valid <= 1'b1;
        end
    end

    // Memory data register samples read data every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mdr <= '0;
        end else begin
            r_mdr <= memrdata;
        end
    end

    perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk       (clk),
        .reset     (reset),
        .irwrite   (irwrite),
        .fetch_cnt (fetch_cnt),
        .cycle_cnt (cycle_cnt)
    );

    assign pc       = r_pc;
    assign instr    = r_instr;
    assign mdr      = r_mdr;
    assign ir_valid = r_ir_valid;
    assign op       = r_instr[c_OP_MSB:c_OP_LSB];
    assign ra       = r_instr[c_RA_MSB:c_RA_LSB];
    assign rb       = r_instr[c_RB_MSB:c_RB_LSB];
    assign rc       = r_instr[c_RC_MSB:c_RC_LSB];
    assign immext   = {{(W-6){r_instr[c_IMM_MSB]}}, r_instr[c_IMM_MSB:c_IMM_LSB]};
    assign jtarget  = w_jtarget;

endmodule : pc_ir_unit
`default_nettype wire
